// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side adapter for the common synchronous FIFO. It drives the FIFO
// read enable, absorbs the FIFO's fixed one-cycle read latency, and
// presents the words as a valid/ready stream through a small circular
// skid buffer. Consumer backpressure never drops a word. A consumer that
// stays ready still receives one word per cycle.
//
// Read credit: a read is only issued when the buffer is guaranteed to
// have room for the returning word. That guarantee counts the words
// already buffered, plus the read still in flight, minus any word leaving
// this cycle.
//
// Optional build macro: FIFO_STREAM_READER_REG_RE_EN
//   When defined, the credit check ignores the word leaving this cycle.
//   This removes the combinational out_ready -> fifo_re path. It needs
//   BUF_DEPTH >= 3 to keep one word per cycle.

module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           fifo_re,
  input  logic                           fifo_empty,
  input  logic                           fifo_rvalid,
  input  logic [WIDTH-1:0]               fifo_rdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count,
  output logic [31:0]                    words_out
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] FULL_OCC = CW'(BUF_DEPTH);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(BUF_DEPTH);

  generate
    if (BUF_DEPTH < 2 || BUF_DEPTH > 8) begin : g_bad_depth
      $error("fifo_stream_reader: BUF_DEPTH must be in the range 2..8");
    end
  endgenerate

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    occ_next;
  logic             pending;
  logic             drop_rvalid;
  logic             push;
  logic             pop;
  logic [CW:0]      committed;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Handshakes: a returning word is captured unless it belongs to a read
  // issued across reset; a word leaves whenever the head is valid and taken.
  always_comb begin
    push      = fifo_rvalid & ~drop_rvalid;
    out_valid = (occ != '0);
    pop       = out_valid & out_ready;
    out_data  = mem[rd_ptr];
    buf_count = occ;
  end

  // Read credit: issue a read only when the returning word is sure to fit.
  always_comb begin
    committed = {1'b0, occ} + {{CW{1'b0}}, pending};
`ifdef FIFO_STREAM_READER_REG_RE_EN
    fifo_re = ~fifo_empty & (committed < CREDIT_LIMIT);
`else
    fifo_re = ~fifo_empty & ((committed - {{CW{1'b0}}, pop}) < CREDIT_LIMIT);
`endif
  end

  // Occupancy bookkeeping: a push and a pop together leave it unchanged.
  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + CW'(1);
      2'b01:   occ_next = occ - CW'(1);
      default: occ_next = occ;
    endcase
  end

  // Control state: pointers, occupancy, in-flight flag and delivered count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      pending     <= 1'b0;
      drop_rvalid <= 1'b1;
      words_out   <= '0;
    end else begin
      drop_rvalid <= 1'b0;
      pending     <= fifo_re & ~fifo_empty;
      occ         <= occ_next;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        words_out <= words_out + 32'd1;
      end
    end
  end

  // Skid storage: data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= fifo_rdata;
    end
  end

  // The credit rule must make a push into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_no_overflow: assert (!(push && occ == FULL_OCC));
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a behavioural FIFO with
// one-cycle read latency feeds the DUT; every word handed to the DUT on
// fifo_rvalid is queued as expected output and compared when popped.
module tb_fifo_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             fifo_re;
  logic             fifo_empty;
  logic             fifo_rvalid;
  logic [WIDTH-1:0] fifo_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    buf_count;
  logic [31:0]      words_out;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(WIDTH), .BUF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_re    (fifo_re),
    .fifo_empty (fifo_empty),
    .fifo_rvalid(fifo_rvalid),
    .fifo_rdata (fifo_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .buf_count  (buf_count),
    .words_out  (words_out)
  );

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;
  int   pending_m = 0;
  bit   prev_reset = 1'b1;
  bit   random_ready = 1'b0;
  int   writes_left = 0;
  int   pop_count = 0;
  int   accept_count = 0;
  int   first_valid_cycle = -1;
  int   first_pop_cycle = -1;
  int   last_pop_cycle = -1;
  logic [WIDTH-1:0] last_pop_data = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One call per cycle: sample at negedge, update scoreboard and FIFO model,
  // drive the next cycle's FIFO outputs just after the rising edge.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      bit pop;
      bit accepted;
      bit re_exp;
      bit nv;
      logic [WIDTH-1:0] nd;
      @(negedge clk);
      pop      = out_valid & out_ready;
      accepted = fifo_re & ~fifo_empty;
      if (reset) begin
        exp_q.delete();
        pending_m = 0;
      end else begin
        checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        checkOutput("buf_count", 32'(buf_count), 32'(exp_q.size()));
`ifdef FIFO_STREAM_READER_REG_RE_EN
        re_exp = !fifo_empty && (exp_q.size() + pending_m < DEPTH);
`else
        re_exp = !fifo_empty && (exp_q.size() + pending_m - int'(pop) < DEPTH);
`endif
        checkOutput("fifo_re", 32'(fifo_re), 32'(re_exp));
        if (out_valid && first_valid_cycle < 0) first_valid_cycle = cycle_no;
        if (pop && exp_q.size() > 0) begin
          checkOutput("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          pop_count++;
          last_pop_data = out_data;
          if (first_pop_cycle < 0) first_pop_cycle = cycle_no;
          last_pop_cycle = cycle_no;
        end
        if (fifo_rvalid && !prev_reset) exp_q.push_back(fifo_rdata);
        pending_m = int'(accepted);
      end
      if (accepted) accept_count++;
      prev_reset = reset;
      cycle_no++;
      nv = accepted;
      nd = fifo_rdata;
      if (accepted && fifo_q.size() > 0) nd = fifo_q.pop_front();
      if (writes_left > 0 && $urandom_range(0, 1) == 1) begin
        fifo_q.push_back(WIDTH'($urandom_range(0, 255)));
        writes_left--;
      end
      @(posedge clk);
      #1;
      fifo_rvalid = nv;
      fifo_rdata  = nd;
      fifo_empty  = (fifo_q.size() == 0);
      if (random_ready) out_ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic preload(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + WIDTH'(i));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  initial begin
    int budget;
    reset       = 1'b1;
    fifo_empty  = 1'b1;
    fifo_rvalid = 1'b0;
    fifo_rdata  = '0;
    out_ready   = 1'b1;

    // Reset state, then a 16-word burst with a always-ready consumer
    applyStimulus(3);
    reset = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_buf_count", 32'(buf_count), 32'd0);
    checkOutput("reset_words_out", words_out, 32'd0);
    checkOutput("reset_fifo_re", 32'(fifo_re), 32'd0);
    preload(16, 8'h01);
    cycle_no = 0;
    first_valid_cycle = -1;
    first_pop_cycle = -1;
    pop_count = 0;
    applyStimulus(24);
    #1;
    checkOutput("burst_latency", 32'(first_valid_cycle), 32'd2);
    checkOutput("burst_pops", 32'(pop_count), 32'd16);
`ifndef FIFO_STREAM_READER_REG_RE_EN
    checkOutput("burst_span", 32'(last_pop_cycle - first_pop_cycle), 32'd15);
`endif
    checkOutput("burst_last", 32'(last_pop_data), 32'h10);
    checkOutput("burst_words_out", words_out, 32'd16);
    checkOutput("burst_buf_count", 32'(buf_count), 32'd0);

    // Backpressure: reads stop once the skid buffer holds DEPTH words
    out_ready = 1'b0;
    accept_count = 0;
    preload(5, 8'h31);
    applyStimulus(3);
    #1;
    checkOutput("bp_hold_early", 32'(out_data), 32'h31);
    applyStimulus(3);
    #1;
    checkOutput("bp_accepts", 32'(accept_count), 32'(DEPTH));
    checkOutput("bp_buf_count", 32'(buf_count), 32'(DEPTH));
    checkOutput("bp_hold_late", 32'(out_data), 32'h31);
    checkOutput("bp_fifo_level", 32'(fifo_q.size()), 32'(5 - DEPTH));
    out_ready = 1'b1;
    pop_count = 0;
    applyStimulus(12);
    #1;
    checkOutput("bp_drain_pops", 32'(pop_count), 32'd5);
    checkOutput("bp_drain_last", 32'(last_pop_data), 32'h35);

    // Single-word FIFO: exactly one accepted read, buffer empties after
    pop_count = 0;
    accept_count = 0;
    preload(1, 8'h41);
    applyStimulus(6);
    #1;
    checkOutput("single_accepts", 32'(accept_count), 32'd1);
    checkOutput("single_pops", 32'(pop_count), 32'd1);
    checkOutput("single_data", 32'(last_pop_data), 32'h41);
    checkOutput("single_idle", 32'(out_valid), 32'd0);

    // Mid-run reset with a full buffer, one read in flight and one issued
    // during the reset cycle; both returning words must be dropped
    out_ready = 1'b0;
    preload(6, 8'h21);
    applyStimulus(4);
    #1;
    checkOutput("mid_buf_full", 32'(buf_count), 32'(DEPTH));
    out_ready = 1'b1;
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    #1;
    checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_buf_count", 32'(buf_count), 32'd0);
    checkOutput("mid_words_out", words_out, 32'd0);
    pop_count = 0;
    applyStimulus(8);
    #1;
    checkOutput("mid_pops", 32'(pop_count), 32'd2);
    checkOutput("mid_last", 32'(last_pop_data), 32'h26);
    checkOutput("mid_words_after", words_out, 32'd2);

    // Random producer and random consumer over 1000 words
    reset = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
    pop_count = 0;
    writes_left = 1000;
    random_ready = 1'b1;
    budget = 0;
    while (pop_count < 1000 && budget < 20000) begin
      applyStimulus(1);
      budget++;
    end
    random_ready = 1'b0;
    out_ready = 1'b1;
    applyStimulus(4);
    #1;
    checkOutput("rand_pops", 32'(pop_count), 32'd1000);
    checkOutput("rand_words_out", words_out, 32'd1000);
    checkOutput("rand_leftover", 32'(exp_q.size()), 32'd0);
    checkOutput("rand_buf_count", 32'(buf_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
